// File: rtl/sync_fifo_mem.sv
// Single-clock FIFO over a simple memory array with occupancy count, almost
// thresholds, sticky error flags and a selectable registered or show-ahead read port.
module sync_fifo_mem #(
   parameter int D_Size   = 8,
   parameter int A_Size   = 9,
   parameter int AF_Level = (1 << A_Size) - 4,
   parameter int AE_Level = 4,
   parameter int OUT_REG  = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              w_inc,
   input  logic [D_Size-1:0] wdata,
   input  logic              r_inc,
   output logic [D_Size-1:0] rdata,
   output logic              rvalid,
   output logic              wfull,
   output logic              rempty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic [A_Size:0]   count,
   output logic              overflow,
   output logic              underflow
);

   localparam int Depth = 1 << A_Size;

   typedef logic [A_Size:0] ptr_t;

   localparam ptr_t AfLvl = ptr_t'(AF_Level);
   localparam ptr_t AeLvl = ptr_t'(AE_Level);

   // Thresholds must fit the depth and leave almost_empty strictly below almost_full.
   if (AF_Level > Depth || AE_Level >= AF_Level) begin : g_param_check
      $error("sync_fifo_mem: illegal AF_Level/AE_Level for this A_Size");
   end

   logic [D_Size-1:0] mem_q [Depth];

   ptr_t wptr_q, wptr_d;
   ptr_t rptr_q, rptr_d;
   logic ovf_q, ovf_d;
   logic udf_q, udf_d;

   logic              wr_en;
   logic              rd_en;
   logic [A_Size-1:0] waddr;
   logic [A_Size-1:0] raddr;

   assign waddr = wptr_q[A_Size-1:0];
   assign raddr = rptr_q[A_Size-1:0];

   // Status decoded from the registered pointers only.
   always_comb begin
      rempty       = (wptr_q == rptr_q);
      wfull        = (wptr_q[A_Size] != rptr_q[A_Size]) &&
                     (wptr_q[A_Size-1:0] == rptr_q[A_Size-1:0]);
      count        = wptr_q - rptr_q;
      almost_full  = (count >= AfLvl);
      almost_empty = (count <= AeLvl);
      overflow     = ovf_q;
      underflow    = udf_q;
   end

   // Accept decisions and pointer/flag next state. A request that is refused
   // only because the opposite side acts in the same cycle (write at full with
   // a read, read at empty with a write) is not an error.
   always_comb begin
      wr_en  = w_inc && !wfull;
      rd_en  = r_inc && !rempty;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      ovf_d  = ovf_q;
      udf_d  = udf_q;
      if (wr_en) wptr_d = wptr_q + ptr_t'(1);
      if (rd_en) rptr_d = rptr_q + ptr_t'(1);
      if (w_inc && wfull && !r_inc)  ovf_d = 1'b1;
      if (r_inc && rempty && !w_inc) udf_d = 1'b1;
   end

   // Pointer and sticky flag registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
         ovf_q  <= 1'b0;
         udf_q  <= 1'b0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         ovf_q  <= ovf_d;
         udf_q  <= udf_d;
      end
   end

   // Storage array; deliberately not reset, contents are discarded via the pointers.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[waddr] <= wdata;
   end

   if (OUT_REG != 0) begin : g_out_reg
      logic [D_Size-1:0] rdata_q, rdata_d;
      logic              rvalid_q, rvalid_d;

      // Capture the head word on each accepted read, otherwise hold.
      always_comb begin
         rdata_d  = rdata_q;
         rvalid_d = rd_en;
         if (rd_en) rdata_d = mem_q[raddr];
      end

      // Registered read data and one-cycle valid pulse.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
         end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
         end
      end

      assign rdata  = rdata_q;
      assign rvalid = rvalid_q;
   end else begin : g_out_comb
      // Show-ahead: head word is visible whenever the FIFO is not empty.
      assign rdata  = mem_q[raddr];
      assign rvalid = !rempty;
   end

endmodule
